// File: rtl/bcd_timer_ctrl_if.sv
// Host-side bundle for the BCD timer sequencer: control, config and status signals.
// Latency: none, wires only; all status outputs are registered in the sequencer.
// Backpressure: none; level-sampled controls, single-cycle DONE/ERR pulses.
//
// Signals
//   START/STOP   level controls sampled every edge
//   MODE         0 = one-shot, 1 = auto-reload
//   TICK         count-enable strobe
//   PRESET/TERM  BCD start and terminal values, digit 0 in bits [3:0]
//   Q            current BCD count
//   BUSY/DONE/ERR status: active, terminal pulse, rejected-start pulse
interface bcd_timer_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  START;
  logic                  STOP;
  logic                  MODE;
  logic                  TICK;
  logic [4*DIGITS-1:0]   PRESET;
  logic [4*DIGITS-1:0]   TERM;
  logic [4*DIGITS-1:0]   Q;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERR;

  modport master (
    output START, STOP, MODE, TICK, PRESET, TERM,
    input  Q, BUSY, DONE, ERR
  );

  modport slave (
    input  START, STOP, MODE, TICK, PRESET, TERM,
    output Q, BUSY, DONE, ERR
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Programmable BCD timer sequencer driving a chain of DIGITS cascaded decade counters.
// Latency: START at edge k loads PRESET at edge k+1; first count possible at edge k+2.
// Backpressure: none; TICK is a qualified strobe, STOP pauses/aborts, all outputs registered.
//
// Ports
//   CLK   clock, rising edge
//   CD    synchronous clear, active-high, overrides everything
//   bus   slave side of bcd_timer_ctrl_if (START/STOP/MODE/TICK/PRESET/TERM in,
//         Q/BUSY/DONE/ERR out)
module bcd_timer_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic              CLK,
  input  logic              CD,
  bcd_timer_ctrl_if.slave   bus
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t         state;
  logic [W-1:0]   q;
  logic           busy;
  logic           done;
  logic           err;

  // True when every nibble of v is a decimal digit.
  function automatic logic all_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Ripple-carry decade increment; all-9s wraps silently to all-0s.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge CLK) begin
    if (CD) begin
      state <= IDLE;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      // Pulses default low; only the branches below raise them.
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.START) begin
            if (all_bcd(bus.PRESET) && all_bcd(bus.TERM)) begin
              state <= LOAD;
              busy  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          q     <= bus.PRESET;
          state <= RUN;
        end
        RUN: begin
          // STOP outranks TICK and START; START has no meaning here.
          if (bus.STOP) begin
            state <= PAUSE;
          end else if (bus.TICK) begin
            if (q == bus.TERM) begin
              done <= 1'b1;
              if (bus.MODE) begin
                q <= bus.PRESET;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              q <= bcd_inc(q);
            end
          end
        end
        PAUSE: begin
          // A second STOP aborts without DONE; resume keeps the held count.
          if (bus.STOP) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bus.START) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Q    = q;
  assign bus.BUSY = busy;
  assign bus.DONE = done;
  assign bus.ERR  = err;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl: directed scenarios plus a randomized run,
// all compared cycle by cycle against an integer-arithmetic reference model.
module tb_bcd_timer_ctrl;

  localparam int DIGITS = 4;
  localparam int MODV   = 10000;

  logic CLK = 1'b0;
  logic CD;
  always #5 CLK = ~CLK;

  bcd_timer_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_timer_ctrl #(.DIGITS(DIGITS)) dut (
    .CLK (CLK),
    .CD  (CD),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: count held as a plain integer, phase as a small integer.
  // 0 = idle, 1 = loading, 2 = running, 3 = paused
  int   m_q;
  int   m_ph;
  logic m_busy;
  logic m_done;
  logic m_err;

  function automatic int bcd2int(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    int          k;
    k = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(k % 10);
      k = k / 10;
    end
    return r;
  endfunction

  function automatic logic is_bcd(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_update();
    m_done = 1'b0;
    m_err  = 1'b0;
    if (CD) begin
      m_ph = 0; m_q = 0; m_busy = 1'b0;
    end else begin
      case (m_ph)
        0: if (bus.START) begin
             if (is_bcd(bus.PRESET) && is_bcd(bus.TERM)) begin m_ph = 1; m_busy = 1'b1; end
             else m_err = 1'b1;
           end
        1: begin m_q = bcd2int(bus.PRESET); m_ph = 2; end
        2: if (bus.STOP) m_ph = 3;
           else if (bus.TICK) begin
             if (m_q == bcd2int(bus.TERM)) begin
               m_done = 1'b1;
               if (bus.MODE) m_q = bcd2int(bus.PRESET);
               else begin m_ph = 0; m_busy = 1'b0; end
             end else m_q = (m_q + 1) % MODV;
           end
        default: if (bus.STOP) begin m_ph = 0; m_busy = 1'b0; end
                 else if (bus.START) m_ph = 2;
      endcase
    end
  endtask

  // Advance one edge, update the model with the inputs seen at that edge,
  // and leave time 1ns after the edge for sampling.
  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.START = 1'b0; bus.STOP = 1'b0; bus.TICK = 1'b0; CD = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.MODE = 1'b0; bus.PRESET = '0; bus.TERM = '0;
    CD = 1'b1;
    step();
    step();
    checks++;
    if (bus.Q !== 16'h0000 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset: Q=%h BUSY=%b DONE=%b ERR=%b, required Q=0000 BUSY=0 DONE=0 ERR=0",
               bus.Q, bus.BUSY, bus.DONE, bus.ERR);
    end
    CD = 1'b0;
  endtask

  task automatic test_oneshot();
    int n;
    bus.PRESET = 16'h0095; bus.TERM = 16'h0102; bus.MODE = 1'b0;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0; bus.TICK = 1'b1;   // TICK during LOAD must be ignored
    step();
    checks++;
    if (bus.Q !== 16'h0095 || bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_load: Q=%h BUSY=%b, required Q=0095 BUSY=1", bus.Q, bus.BUSY);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      checks++;
      if (bus.Q !== int2bcd(m_q) || bus.BUSY !== m_busy || bus.DONE !== m_done || bus.ERR !== m_err) begin
        errors++;
        $display("FAIL oneshot_step%0d: Q=%h BUSY=%b DONE=%b ERR=%b, required Q=%h BUSY=%b DONE=%b ERR=%b",
                 i, bus.Q, bus.BUSY, bus.DONE, bus.ERR, int2bcd(m_q), m_busy, m_done, m_err);
      end
      if (bus.DONE === 1'b1) break;
    end
    checks++;
    if (n != 8 || bus.Q !== 16'h0102 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_term: ticks=%0d Q=%h BUSY=%b, required ticks=8 Q=0102 BUSY=0",
               n, bus.Q, bus.BUSY);
    end
    bus.TICK = 1'b0;
    step();
    checks++;
    if (bus.DONE !== 1'b0 || bus.Q !== 16'h0102) begin
      errors++;
      $display("FAIL oneshot_after: DONE=%b Q=%h, required DONE=0 Q=0102", bus.DONE, bus.Q);
    end
  endtask

  task automatic test_autoreload();
    int ndone;
    int bad_pos;
    bus.PRESET = 16'h9998; bus.TERM = 16'h0001; bus.MODE = 1'b1;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    step();
    bus.TICK = 1'b1;
    ndone = 0; bad_pos = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if (bus.Q !== int2bcd(m_q) || bus.BUSY !== m_busy || bus.DONE !== m_done || bus.ERR !== m_err) begin
        errors++;
        $display("FAIL reload_step%0d: Q=%h BUSY=%b DONE=%b ERR=%b, required Q=%h BUSY=%b DONE=%b ERR=%b",
                 i, bus.Q, bus.BUSY, bus.DONE, bus.ERR, int2bcd(m_q), m_busy, m_done, m_err);
      end
      if (bus.DONE === 1'b1) begin
        ndone++;
        if (i % 4 != 0 || bus.Q !== 16'h9998) bad_pos++;
      end
    end
    checks++;
    if (ndone != 3 || bad_pos != 0) begin
      errors++;
      $display("FAIL reload_period: dones=%0d misplaced=%0d, required dones=3 misplaced=0", ndone, bad_pos);
    end
    bus.TICK = 1'b0; bus.STOP = 1'b1;
    step();
    step();
    bus.STOP = 1'b0;
    checks++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      errors++;
      $display("FAIL reload_abort: BUSY=%b DONE=%b, required BUSY=0 DONE=0", bus.BUSY, bus.DONE);
    end
  endtask

  task automatic test_err();
    logic [15:0] q_before;
    q_before = bus.Q;
    bus.PRESET = 16'h00A0; bus.TERM = 16'h0100;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    checks++;
    if (bus.ERR !== 1'b1 || bus.BUSY !== 1'b0 || bus.Q !== q_before) begin
      errors++;
      $display("FAIL err_pulse: ERR=%b BUSY=%b Q=%h, required ERR=1 BUSY=0 Q=%h",
               bus.ERR, bus.BUSY, bus.Q, q_before);
    end
    step();
    checks++;
    if (bus.ERR !== 1'b0 || bus.BUSY !== 1'b0 || bus.Q !== q_before) begin
      errors++;
      $display("FAIL err_clear: ERR=%b BUSY=%b Q=%h, required ERR=0 BUSY=0 Q=%h",
               bus.ERR, bus.BUSY, bus.Q, q_before);
    end
  endtask

  task automatic test_pause();
    logic held_ok;
    bus.PRESET = 16'h0040; bus.TERM = 16'h0900; bus.MODE = 1'b0;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    step();
    bus.TICK = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.STOP = 1'b1;               // TICK still high: must be ignored
    step();
    bus.STOP = 1'b0;
    held_ok = (bus.Q === 16'h0050) && (bus.BUSY === 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.Q !== 16'h0050) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok || bus.Q !== int2bcd(m_q)) begin
      errors++;
      $display("FAIL pause_hold: Q=%h BUSY=%b, required Q=0050 BUSY=1 throughout pause", bus.Q, bus.BUSY);
    end
    bus.TICK = 1'b0; bus.START = 1'b1;
    step();
    bus.START = 1'b0; bus.TICK = 1'b1;
    step();
    checks++;
    if (bus.Q !== 16'h0051 || bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume: Q=%h BUSY=%b, required Q=0051 BUSY=1", bus.Q, bus.BUSY);
    end
    bus.TICK = 1'b0; bus.STOP = 1'b1;
    step();
    step();
    bus.STOP = 1'b0;
    checks++;
    if (bus.Q !== 16'h0051 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      errors++;
      $display("FAIL pause_abort: Q=%h BUSY=%b DONE=%b, required Q=0051 BUSY=0 DONE=0",
               bus.Q, bus.BUSY, bus.DONE);
    end
  endtask

  task automatic test_stop_priority();
    bus.PRESET = 16'h0200; bus.TERM = 16'h0300; bus.MODE = 1'b0;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0; bus.TICK = 1'b1;
    step();
    step();
    step();
    checks++;
    if (bus.Q !== 16'h0202) begin
      errors++;
      $display("FAIL prio_load: Q=%h, required Q=0202", bus.Q);
    end
    bus.START = 1'b1; bus.STOP = 1'b1;   // in RUN: STOP wins, TICK ignored
    step();
    checks++;
    if (bus.Q !== 16'h0202 || bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL prio_run: Q=%h BUSY=%b, required Q=0202 BUSY=1", bus.Q, bus.BUSY);
    end
    step();                              // in PAUSE: STOP wins -> idle
    bus.START = 1'b0; bus.STOP = 1'b0; bus.TICK = 1'b0;
    checks++;
    if (bus.Q !== 16'h0202 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      errors++;
      $display("FAIL prio_pause: Q=%h BUSY=%b DONE=%b, required Q=0202 BUSY=0 DONE=0",
               bus.Q, bus.BUSY, bus.DONE);
    end
  endtask

  task automatic test_cd_midcount();
    bus.PRESET = 16'h0100; bus.TERM = 16'h0900; bus.MODE = 1'b0;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    step();
    bus.TICK = 1'b1;
    for (int i = 0; i < 23; i++) step();
    checks++;
    if (bus.Q !== 16'h0123) begin
      errors++;
      $display("FAIL cd_pre: Q=%h, required Q=0123", bus.Q);
    end
    CD = 1'b1;
    step();
    CD = 1'b0;
    checks++;
    if (bus.Q !== 16'h0000 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.ERR !== 1'b0) begin
      errors++;
      $display("FAIL cd_clear: Q=%h BUSY=%b DONE=%b ERR=%b, required Q=0000 BUSY=0 DONE=0 ERR=0",
               bus.Q, bus.BUSY, bus.DONE, bus.ERR);
    end
    step();                              // TICK still high, must stay idle
    bus.TICK = 1'b0;
    checks++;
    if (bus.Q !== 16'h0000 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL cd_idle: Q=%h BUSY=%b, required Q=0000 BUSY=0", bus.Q, bus.BUSY);
    end
  endtask

  task automatic test_random();
    int p;
    int bad;
    bad = 0;
    for (int i = 0; i < 4000; i++) begin
      // Occasionally reprogram; non-BCD values only offered while idle so Q stays BCD.
      if ($urandom_range(0, 19) == 0) begin
        p = $urandom_range(0, MODV - 1);
        bus.PRESET = int2bcd(p);
        bus.TERM   = int2bcd((p + $urandom_range(0, 25)) % MODV);
        if (m_ph == 0 && $urandom_range(0, 3) == 0) bus.TERM[4*$urandom_range(0, 3) +: 4] = 4'hB;
      end else if (m_ph != 0 && !(is_bcd(bus.TERM) && is_bcd(bus.PRESET))) begin
        bus.PRESET = int2bcd(m_q);
        bus.TERM   = int2bcd((m_q + 7) % MODV);
      end
      bus.MODE  = ($urandom_range(0, 1) == 1);
      bus.TICK  = ($urandom_range(0, 3) != 0);
      bus.START = ($urandom_range(0, 5) == 0);
      bus.STOP  = ($urandom_range(0, 24) == 0);
      CD        = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if (bus.Q !== int2bcd(m_q) || bus.BUSY !== m_busy || bus.DONE !== m_done || bus.ERR !== m_err) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cyc%0d: Q=%h BUSY=%b DONE=%b ERR=%b, required Q=%h BUSY=%b DONE=%b ERR=%b",
                   i, bus.Q, bus.BUSY, bus.DONE, bus.ERR, int2bcd(m_q), m_busy, m_done, m_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_err();
    test_pause();
    test_stop_priority();
    test_cd_midcount();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
